count_seq_ctrl: RTL and testbench
=================================

// Module: count_seq_ctrl
// PURPOSE
//  Sequencer for the gate-level 4-bit counter: presets it, gates its active-low enable EC,
//  watches its Q outputs and runs a programmed number of count passes per start command.
//  A pass ends when Q equals a programmed stop value. A watchdog flags a counter that never
//  reaches that value. Sits between the control logic (start/done handshake) and one counter.
// PARAMETERS
//  WIDTH_P    8   width of passes / pass_cnt
//  WDOG_LIM   16  enabled RUN cycles allowed per pass before err
// PORTS
//  clk       in   1        system clock; the counter is clocked from the same clk
//  r         in   1        reset, asynchronous, active-high
//  start     in   1        1-cycle request; sampled only in IDLE or ERR
//  passes    in   WIDTH_P  passes per run; latched on accepted start; 0 means 2**WIDTH_P
//  stop_val  in   4        terminal Q value; latched on accepted start
//  hold      in   1        pause: EC forced 1, watchdog frozen, state kept
//  abort     in   1        cancel the run from any non-IDLE state
//  q_in      in   4        counter Q[3:0]
//  cnt_r     out  1        counter preset request; counter goes to 4'hF while high
//  EC        out  1        counter enable, active-low (0 = count)
//  busy      out  1        high in CLR/RUN
//  done      out  1        1-cycle pulse when the last pass completes
//  err       out  1        watchdog error; held until start or r
//  pass_cnt  out  WIDTH_P  passes completed in the current/last run
// BEHAVIOUR
//  - Reset (r=1, async): state=IDLE, cnt_r=1, EC=1, busy=0, done=0, err=0, pass_cnt=0.
//  - All outputs are registered. The counter steps once on each clk edge at which EC=0.
//  - States: IDLE, CLR, RUN, ERR.
//  - IDLE: cnt_r=0, EC=1. start=1 -> latch passes/stop_val, pass_cnt<=0 -> CLR.
//  - CLR (exactly 1 cycle): cnt_r=1, EC=1, wdog<=0 -> RUN.
//  - RUN: EC=0 unless hold=1. Each edge compares q_in (unregistered) with stop_val.
//  - On match with EC=0: pass_cnt++.
//  - After that match, if pass_cnt+1 == passes (mod 2**WIDTH_P): done pulse, EC<=1 -> IDLE.
//  - Otherwise -> CLR for the next pass.
//  - The counter makes one overshoot step on the match edge. This is accepted: CLR follows.
//  - stop_val == 4'hF does not match the preset value. The first step must leave 4'hF,
//    so a pass can only match after a full counter cycle.
//  - Watchdog: wdog increments each RUN cycle with EC=0 and no match.
//    wdog == WDOG_LIM-1 with no match -> err<=1, EC<=1 -> ERR.
//  - ERR: EC=1, cnt_r=0. start clears err and behaves exactly as start in IDLE.
//  - abort (any non-IDLE state; priority over match/watchdog/start) -> IDLE next edge.
//    EC<=1, done stays 0, err cleared, pass_cnt kept for debug.
//  - start while busy is ignored. Simultaneous start+abort in ERR: abort wins.
//  - hold in CLR is ignored (CLR still lasts 1 cycle). hold in IDLE/ERR has no effect.
//  - pass_cnt counts modulo 2**WIDTH_P. With passes=0 the run ends at 256 passes (pass_cnt=0).
// TESTING
//  1 Reset: assert r mid-RUN -> EC=1, cnt_r=1, busy=0, pass_cnt=0 immediately (async).
//  2 passes=3, stop_val=4'h0, model counter -> 3 CLR pulses, pass_cnt 1,2,3, one done, EC=1 after.
//  3 stop_val not in counter sequence -> err=1 after 16 enabled RUN cycles; later start clears err.
//  4 hold=1 for 5 cycles mid-pass -> EC=1, wdog frozen, q_in static; pass completes after release.
//  5 abort on the same edge as the final match -> IDLE, done=0, pass_cnt keeps pre-match value.
//  6 passes=0, stop_val=4'h8 -> 256 passes, then done, pass_cnt wraps to 0; start while busy ignored.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequences a 4-bit counter through a programmed number of count passes per start.
//   clk      system clock, shared with the counter
//   r        asynchronous active-high reset
//   start    run request, accepted in IDLE or ERR
//   passes   passes per run, 0 = 2**WIDTH_P
//   stop_val terminal counter value for each pass
//   hold     pause: counter disabled, watchdog frozen
//   abort    cancel from any non-IDLE state
//   q_in     counter Q[3:0]
//   cnt_r    counter preset request (counter goes to 4'hF)
//   EC       counter enable, active-low
//   busy     high in CLR/RUN
//   done     one-cycle pulse at end of the last pass
//   err      watchdog error, held until start or r
//   pass_cnt passes completed in the current/last run
module count_seq_ctrl #(
    parameter int WIDTH_P  = 8,
    parameter int WDOG_LIM = 16
) (
    input  logic               clk,
    input  logic               r,
    input  logic               start,
    input  logic [WIDTH_P-1:0] passes,
    input  logic [3:0]         stop_val,
    input  logic               hold,
    input  logic               abort,
    input  logic [3:0]         q_in,
    output logic               cnt_r,
    output logic               EC,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH_P-1:0] pass_cnt
);
    localparam int WW = (WDOG_LIM > 1) ? $clog2(WDOG_LIM) : 1;
    typedef enum logic [1:0] {IDLE, CLR, RUN, ERR} state_t;
    state_t             state, state_nx;
    logic [WW-1:0]      wdog;
    logic [WIDTH_P-1:0] passes_q, pass_inc;
    logic [3:0]         stop_q;
    logic               kill, accept, match, last;
    assign pass_inc = pass_cnt + WIDTH_P'(1);
    assign kill     = abort && state != IDLE;
    assign accept   = start && !kill && (state == IDLE || state == ERR);
    // a match only counts while the counter is actually enabled this edge
    assign match    = state == RUN && !EC && q_in == stop_q;
    // wraps modulo 2**WIDTH_P, so passes=0 ends after the full 2**WIDTH_P passes
    assign last     = pass_inc == passes_q;
    always_comb begin
        state_nx = state;
        if (kill) state_nx = IDLE;
        else if (accept) state_nx = CLR;
        else if (state == CLR) state_nx = RUN;
        else if (match) state_nx = last ? IDLE : CLR;
        else if (state == RUN && !EC && wdog == WW'(WDOG_LIM - 1)) state_nx = ERR;
    end
    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state    <= IDLE;
            cnt_r    <= 1'b1;
            EC       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            wdog     <= '0;
            passes_q <= '0;
            stop_q   <= '0;
        end else begin
            state <= state_nx;
            cnt_r <= state_nx == CLR;
            EC    <= !(state_nx == RUN && !hold);
            busy  <= state_nx == CLR || state_nx == RUN;
            done  <= match && last && !kill;
            err   <= state_nx == ERR;
            if (accept) begin
                passes_q <= passes;
                stop_q   <= stop_val;
                pass_cnt <= '0;
            end else if (match && !kill) begin
                pass_cnt <= pass_inc;
            end
            if (state == CLR) wdog <= '0;
            else if (state == RUN && !EC && !match) wdog <= wdog + WW'(1);
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed checks of count_seq_ctrl against a modelled mod-10 counter.
module tb_count_seq_ctrl;
    logic       clk = 1'b0;
    logic       r, start, hold, abort;
    logic [7:0] passes, pass_cnt;
    logic [3:0] stop_val, q;
    logic       cnt_r, EC, busy, done, err;
    int         n_cmp = 0, n_bad = 0;
    int         cyc, n_done, n_clr, done_at, err_at;

    count_seq_ctrl dut (
        .clk(clk), .r(r), .start(start), .passes(passes), .stop_val(stop_val),
        .hold(hold), .abort(abort), .q_in(q), .cnt_r(cnt_r), .EC(EC),
        .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // counter: preset to F while cnt_r high, else counts 0..9 when EC=0 (A..E never occur)
    always @(posedge clk or posedge cnt_r)
        if (cnt_r) q <= 4'hF;
        else if (!EC) q <= (q >= 4'd9) ? 4'd0 : q + 4'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input logic [7:0] p, input logic [3:0] s);
        passes = p;
        stop_val = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_done = 0;
        n_clr = 0;
        done_at = 0;
        err_at = 0;
    endtask

    task automatic mon(input int n);
        repeat (n) begin
            if (done) begin
                n_done++;
                done_at = cyc;
            end
            if (err && err_at == 0) err_at = cyc;
            if (cnt_r) n_clr++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        r = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; passes = 8'd0; stop_val = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_cntr", cnt_r, 1); chk("rst_ec", EC, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_pc", pass_cnt, 0);
        r = 1'b0;
        @(negedge clk);
        chk("idle_cntr", cnt_r, 0); chk("idle_ec", EC, 1);

        // three passes to 0: each pass is CLR + two RUN cycles
        go(8'd3, 4'h0);
        chk("t2_clr_busy", busy, 1); chk("t2_clr_cntr", cnt_r, 1);
        mon(12);
        chk("t2_clr_pulses", n_clr, 3); chk("t2_dones", n_done, 1);
        chk("t2_done_at", done_at, 10); chk("t2_pc", pass_cnt, 3);
        chk("t2_ec", EC, 1); chk("t2_busy", busy, 0);

        // stop value outside the counter sequence trips the watchdog
        go(8'd1, 4'hA);
        mon(20);
        chk("t3_err_at", err_at, 18); chk("t3_err", err, 1); chk("t3_ec", EC, 1);
        chk("t3_busy", busy, 0); chk("t3_dones", n_done, 0);
        go(8'd1, 4'h0);
        chk("t3_err_clr", err, 0); chk("t3_restart_busy", busy, 1);
        mon(5);
        chk("t3_done_at", done_at, 4); chk("t3_pc", pass_cnt, 1);

        // hold for 5 edges mid-pass delays the match by 5 cycles
        go(8'd1, 4'h5);
        mon(3);
        hold = 1'b1;
        mon(2);
        chk("t4_hold_ec", EC, 1); chk("t4_hold_q0", q, 2); chk("t4_hold_busy", busy, 1);
        mon(3);
        chk("t4_hold_q1", q, 2);
        hold = 1'b0;
        mon(8);
        chk("t4_done_at", done_at, 14); chk("t4_dones", n_done, 1);
        chk("t4_err", err_at, 0); chk("t4_pc", pass_cnt, 1);

        // abort on the edge of the final match
        go(8'd2, 4'h0);
        mon(5);
        abort = 1'b1;
        mon(1);
        abort = 1'b0;
        chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_pc", pass_cnt, 1);
        chk("t5_ec", EC, 1); chk("t5_cntr", cnt_r, 0);
        mon(3);
        chk("t5_dones", n_done, 0);

        // start and abort together in ERR: abort wins
        go(8'd1, 4'hB);
        mon(20);
        chk("t5b_err", err, 1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5b_err_clr", err, 0); chk("t5b_busy", busy, 0); chk("t5b_cntr", cnt_r, 0);

        // passes=0 runs 256 passes of 11 cycles; start while busy is ignored
        go(8'd0, 4'h8);
        mon(3);
        passes = 8'd5; stop_val = 4'h0; start = 1'b1;
        mon(1);
        start = 1'b0;
        mon(1095);
        chk("t6_pc_mid", pass_cnt, 99); chk("t6_busy_mid", busy, 1);
        mon(1730);
        chk("t6_done_at", done_at, 2817); chk("t6_dones", n_done, 1);
        chk("t6_clr_pulses", n_clr, 256); chk("t6_pc_wrap", pass_cnt, 0);
        chk("t6_busy", busy, 0);

        // asynchronous reset in the middle of a pass
        go(8'd3, 4'h0);
        mon(5);
        chk("t1_pre_ec", EC, 0); chk("t1_pre_pc", pass_cnt, 1);
        #2 r = 1'b1;
        #1;
        chk("t1_ec", EC, 1); chk("t1_cntr", cnt_r, 1);
        chk("t1_busy", busy, 0); chk("t1_pc", pass_cnt, 0);
        @(negedge clk);
        r = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
